// File: rtl/sw_debounce8_pkg.sv
// Shared constants and types for the switch debounce front end of the
// 8-to-3 priority encoder.
package sw_pkg;

  localparam int NUM_SW            = 8;
  localparam int STABLE_CYCLES_DEF = 4;
  // Board setting: 10 ms at 50 MHz.
  localparam int DEBOUNCE_10MS     = 500000;

  typedef logic [NUM_SW-1:0] sw_vec_t;

endpackage

// File: rtl/sw_debounce8_if.sv
// Signal bundle between the debounce stage and its neighbours.
// Optional macro SW_DEBOUNCE8_EDGE_EN adds the per-bit rise/fall strobes.
interface sw_debounce8_if;
  import sw_pkg::*;

  sw_vec_t sw_raw;   // asynchronous switch levels
  sw_vec_t x_db;     // debounced vector, feeds encoder x
  logic    any_on;   // |x_db, registered with x_db
  logic    changed;  // one-cycle pulse when x_db takes a new value
  logic    busy;     // some bit is mid-debounce

`ifdef SW_DEBOUNCE8_EDGE_EN
  sw_vec_t rise;
  sw_vec_t fall;

  modport master (output sw_raw, input x_db, any_on, changed, busy, rise, fall);
  modport slave  (input sw_raw, output x_db, any_on, changed, busy, rise, fall);
`else
  modport master (output sw_raw, input x_db, any_on, changed, busy);
  modport slave  (input sw_raw, output x_db, any_on, changed, busy);
`endif

endinterface

// File: rtl/sw_debounce8_debounce_bit.sv
// Single-bit conditioner: two-flop synchroniser, disagreement counter and
// debounced output flop. The counter runs only while the synchronised level
// disagrees with the debounced level and the new level is accepted after
// STABLE_CYCLES consecutive disagreeing edges.
module debounce_bit #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_db,
  output logic o_db_next,
  output logic o_busy
);

  localparam int             CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_db_next;

  // Next counter / debounced value from the synchronised sample.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    w_cnt_next = r_cnt;
    w_db_next  = r_db;
    if (r_s2 == r_db) begin
      w_cnt_next = '0;
    end else if (r_cnt == CNT_MAX) begin
      w_db_next  = r_s2;
      w_cnt_next = '0;
    end else begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  // Synchroniser, counter and output flop with synchronous clear.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value
    // of its neighbour; blocking here would collapse the synchroniser.
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else begin
      r_s1  <= i_raw;
      r_s2  <= r_s1;
      r_cnt <= w_cnt_next;
      r_db  <= w_db_next;
    end
  end

  assign o_db      = r_db;
  assign o_db_next = w_db_next;
  assign o_busy    = (r_cnt != '0);

endmodule

// File: rtl/sw_debounce8.sv
// Eight-switch debounce stage ahead of the 8-to-3 priority encoder.
// Each bit is conditioned independently by debounce_bit; this level adds the
// change strobe, any_on and busy. Defining SW_DEBOUNCE8_EDGE_EN adds the
// registered per-bit rise/fall strobes on the interface.
module sw_debounce8
  import sw_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  sw_debounce8_if.slave  bus
);

  sw_vec_t w_db;
  sw_vec_t w_db_next;
  sw_vec_t w_busy;
  sw_vec_t w_diff;
  logic    r_any_on;
  logic    r_changed;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .rst       (rst),
      .i_raw     (bus.sw_raw[i]),
      .o_db      (w_db[i]),
      .o_db_next (w_db_next[i]),
      .o_busy    (w_busy[i])
    );
  end

  // Bits that will flip on the coming edge.
  assign w_diff = w_db_next ^ w_db;

`ifdef SW_DEBOUNCE8_EDGE_EN
  sw_vec_t r_rise;
  sw_vec_t r_fall;

  // Status and edge strobes registered on the same edge x_db updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_any_on  <= 1'b0;
      r_changed <= 1'b0;
      r_rise    <= '0;
      r_fall    <= '0;
    end else begin
      r_any_on  <= |w_db_next;
      r_changed <= |w_diff;
      r_rise    <= w_diff & w_db_next;
      r_fall    <= w_diff & w_db;
    end
  end

  assign bus.rise = r_rise;
  assign bus.fall = r_fall;
`else
  // Status registered on the same edge x_db updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_any_on  <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_any_on  <= |w_db_next;
      r_changed <= |w_diff;
    end
  end
`endif

  assign bus.x_db    = w_db;
  assign bus.any_on  = r_any_on;
  assign bus.changed = r_changed;
  assign bus.busy    = |w_busy;

endmodule
